// File: rtl/prog_loader.sv
// prog_loader
//   Streams a configuration image, byte by byte, into a serial shift chain.
//   Each byte is shifted LSB first. Each bit has a prog_clk low phase (SETUP)
//   and a high phase (HIGH), and each phase lasts DIV clk cycles. Optionally,
//   the bits that fall out of the chain tail (prog_out) are collected into
//   readback bytes.
//
//   Build option: define PROG_LOADER_READBACK_EN to include readback capture.
//   Without it, rb_data is tied to 0, rb_valid is tied to 0 and prog_out is
//   ignored. The prog_* timing is the same in both builds.
//
// Parameters
//   CHAIN_LEN  number of bits in the target chain (multiple of 8)
//   DIV        clk cycles per prog_clk phase (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, begins a pass (ignored unless idle)
//   in_data    configuration byte, bit 0 shifted first
//   in_valid   in_data holds a byte
//   in_ready   byte accepted when in_valid && in_ready
//   prog_in    serial bit to the chain
//   prog_clk   chain shift clock
//   prog_en    chain shift enable
//   prog_out   chain tail (previous configuration)
//   rb_data    readback byte
//   rb_valid   one-cycle pulse qualifying rb_data
//   busy       pass in progress
//   done       one-cycle pulse at pass completion
module prog_loader #(
  parameter int CHAIN_LEN = 1480,
  parameter int DIV       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       prog_in,
  output logic       prog_clk,
  output logic       prog_en,
  input  logic       prog_out,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, HIGH, FINISH} state_t;

  state_t           state, state_nxt;
  logic [7:0]       byte_q;
  logic [2:0]       idx;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic             div_last;
  logic             bit_last;
  logic             enter_setup;
  logic [2:0]       idx_entry;
  logic [7:0]       byte_src;

  assign div_last    = (div_cnt == DIV_LAST);
  assign bit_last    = (bit_cnt == LAST_BIT);
  assign enter_setup = (state_nxt == SETUP) && (state != SETUP);
  // SETUP is entered either straight from a handshake (bit 0 of the incoming
  // byte) or from HIGH (next bit of the held byte).
  assign idx_entry   = (state == FETCH) ? 3'd0 : idx + 3'd1;
  assign byte_src    = (state == FETCH) ? in_data : byte_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start)    state_nxt = FETCH;
      FETCH:  if (in_valid) state_nxt = SETUP;
      SETUP:  if (div_last) state_nxt = HIGH;
      HIGH: begin
        if (div_last) begin
          if (idx != 3'd7)   state_nxt = SETUP;
          else if (bit_last) state_nxt = FINISH;
          else               state_nxt = FETCH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    prog_clk = 1'b0;
    prog_en  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE:   busy = 1'b0;
      FETCH: begin
        in_ready = 1'b1;
        prog_en  = 1'b1;
      end
      SETUP:  prog_en = 1'b1;
      HIGH: begin
        prog_en  = 1'b1;
        prog_clk = 1'b1;
      end
      FINISH: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_q  <= '0;
      idx     <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      prog_in <= 1'b0;
    end else begin
      // Phase timer restarts on every state change.
      if (state != state_nxt)
        div_cnt <= '0;
      else if (state == SETUP || state == HIGH)
        div_cnt <= div_cnt + DIV_W'(1);

      if (state == IDLE && start)
        bit_cnt <= '0;

      if (state == FETCH && in_valid) begin
        byte_q <= in_data;
        idx    <= '0;
      end

      // prog_in changes only on entry to SETUP, where prog_clk is low.
      if (enter_setup)
        prog_in <= byte_src[idx_entry];

      if (state == HIGH && div_last) begin
        idx     <= idx + 3'd1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PROG_LOADER_READBACK_EN
  logic [7:0] rb_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      // The tail still holds the old bit because no rising edge has occurred yet.
      if (enter_setup)
        rb_shift[idx_entry] <= prog_out;
      if (state == HIGH && div_last && idx == 3'd7) begin
        rb_data  <= rb_shift;
        rb_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_prog_out;

  assign unused_prog_out = prog_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Directed bench for prog_loader.
//   u_dut  uses CHAIN_LEN=16, DIV=1 and drives a 16-bit behavioural chain.
//   u_dut3 uses CHAIN_LEN=8, DIV=3 and is used for the phase-timing checks.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, prog_in, prog_clk, prog_en;
  logic [7:0] rb_data;
  logic       rb_valid, busy, done;

  logic       start3, in_valid3;
  logic [7:0] in_data3;
  logic       in_ready3, prog_in3, prog_clk3, prog_en3;
  logic [7:0] rb_data3;
  logic       rb_valid3, busy3, done3;
  logic       prog_out3 = 1'b0;

  logic [15:0] chain = '0;

  prog_loader #(.CHAIN_LEN(16), .DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .prog_in(prog_in),
    .prog_clk(prog_clk), .prog_en(prog_en), .prog_out(chain[0]),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  prog_loader #(.CHAIN_LEN(8), .DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .prog_in(prog_in3),
    .prog_clk(prog_clk3), .prog_en(prog_en3), .prog_out(prog_out3),
    .rb_data(rb_data3), .rb_valid(rb_valid3), .busy(busy3), .done(done3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural chain: shifts toward the tail (bit 0) on each prog_clk rise.
  int   edge_cnt = 0;
  logic edge_bits [256];
  always @(posedge prog_clk) begin
    chain                    <= {prog_in, chain[15:1]};
    edge_bits[edge_cnt & 255] <= prog_in;
    edge_cnt                 <= edge_cnt + 1;
  end

  int         rb_cnt = 0;
  logic [7:0] rb_log [16];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (rb_valid) begin
      rb_log[rb_cnt & 15] <= rb_data;
      rb_cnt              <= rb_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  logic clk3_log [1024];
  logic pin3_log [1024];
  always @(negedge clk) begin
    clk3_log[cyc % 1024] <= prog_clk3;
    pin3_log[cyc % 1024] <= prog_in3;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one pass on u_dut. stall: cycles in_valid is withheld before the
  // second byte. poke: pulse start again while the pass is busy.
  task automatic pass1(input logic [7:0] b0, input logic [7:0] b1,
                       input int stall, input bit poke, output int len);
    int t0;
    int k;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = b0; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    if (stall > 0) begin
      in_valid = 1'b0;
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      for (int i = 0; i < stall; i++) begin
        chk("stall_prog_en", prog_en, 1);
        chk("stall_prog_clk", prog_clk, 0);
        chk("stall_busy", busy, 1);
        @(negedge clk);
      end
      in_valid = 1'b1;
    end
    in_data = b1;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (!done && k < 1000) begin @(negedge clk); k++; end
    chk("done_seen", done, 1);
    len = cyc - t0 + 1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int          len, e0, r0, d0, t0, d, k, run, nhigh, viol;
    logic [15:0] s;
    logic [7:0]  got;
    logic        prev, c, seen_high;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {prog_in, prog_clk, prog_en, in_ready, rb_data, rb_valid, busy, done}, 0);
    chk("reset_outs3", {prog_in3, prog_clk3, prog_en3, in_ready3, rb_data3, rb_valid3, busy3, done3}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass 1: 0xA5, 0x3C back-to-back into an all-zero chain.
    e0 = edge_cnt; r0 = rb_cnt;
    pass1(8'hA5, 8'h3C, 0, 1'b0, len);
    chk("p1_len", len, 36);
    chk("p1_edges", edge_cnt - e0, 16);
    for (int i = 0; i < 16; i++) s[i] = edge_bits[(e0 + i) & 255];
    chk("p1_stream", s, 16'b0011_1100_1010_0101);
`ifdef PROG_LOADER_READBACK_EN
    chk("p1_rb_cnt", rb_cnt - r0, 2);
    chk("p1_rb0", rb_log[r0 & 15], 8'h00);
    chk("p1_rb1", rb_log[(r0 + 1) & 15], 8'h00);
`else
    chk("p1_rb_cnt", rb_cnt - r0, 0);
`endif

    // Pass 2: same image, 50-cycle gap before the second byte.
    e0 = edge_cnt; r0 = rb_cnt;
    pass1(8'hA5, 8'h3C, 50, 1'b0, len);
    chk("p2_edges", edge_cnt - e0, 16);
    for (int i = 0; i < 16; i++) s[i] = edge_bits[(e0 + i) & 255];
    chk("p2_stream", s, 16'h3CA5);
`ifdef PROG_LOADER_READBACK_EN
    chk("p2_rb_cnt", rb_cnt - r0, 2);
    chk("p2_rb0", rb_log[r0 & 15], 8'hA5);
    chk("p2_rb1", rb_log[(r0 + 1) & 15], 8'h3C);
`else
    chk("p2_rb_cnt", rb_cnt - r0, 0);
`endif

    // Pass 3: reset after 5 bits of 0x5A.
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt; d0 = done_cnt;
    k = 0;
    while ((edge_cnt - e0) < 5 && k < 200) begin @(negedge clk); k++; end
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {prog_in, prog_clk, prog_en, in_ready, rb_data, rb_valid, busy, done}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_edges", edge_cnt - e0, 5);
    chk("midrst_no_done", done_cnt - d0, 0);

    // Pass 4: full pass after reset, with start pulsed while busy.
    // Chain now holds {5A[4:0], 3CA5[15:5]} = 0xD1E5.
    e0 = edge_cnt; r0 = rb_cnt;
    pass1(8'hC3, 8'h81, 0, 1'b1, len);
    chk("p4_len", len, 36);
    chk("p4_edges", edge_cnt - e0, 16);
    for (int i = 0; i < 16; i++) s[i] = edge_bits[(e0 + i) & 255];
    chk("p4_stream", s, 16'h81C3);
    repeat (4) @(negedge clk);
    chk("p4_edges_after", edge_cnt - e0, 16);
    chk("p4_idle", busy, 0);
`ifdef PROG_LOADER_READBACK_EN
    chk("p4_rb_cnt", rb_cnt - r0, 2);
    chk("p4_rb0", rb_log[r0 & 15], 8'hE5);
    chk("p4_rb1", rb_log[(r0 + 1) & 15], 8'hD1);
`else
    chk("p4_rb_cnt", rb_cnt - r0, 0);
`endif

    // DIV=3 unit, 8-bit chain, byte 0x96.
    @(negedge clk);
    start3 = 1'b1; in_valid3 = 1'b1; in_data3 = 8'h96; t0 = cyc;
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (!done3 && k < 500) begin @(negedge clk); k++; end
    chk("div3_done_seen", done3, 1);
    d = cyc;
    chk("div3_len", d - t0 + 1, 51);
    in_valid3 = 1'b0;
    @(negedge clk);
    prev = clk3_log[t0 % 1024]; run = 1; seen_high = 1'b0;
    nhigh = 0; viol = 0; got = '0;
    for (int i = t0 + 1; i <= d; i++) begin
      c = clk3_log[i % 1024];
      if (pin3_log[i % 1024] !== pin3_log[(i - 1) % 1024] && c) viol++;
      if (c == prev) run++;
      else begin
        if (prev) begin
          chk("div3_high_phase", run, 3);
          seen_high = 1'b1;
        end else if (seen_high) begin
          chk("div3_low_phase", run, 3);
        end
        if (c) begin
          if (nhigh < 8) got[nhigh] = pin3_log[i % 1024];
          nhigh++;
        end
        run = 1; prev = c;
      end
    end
    chk("div3_edges", nhigh, 8);
    chk("div3_stream", got, 8'h96);
    chk("div3_pin_stable_high", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
